// File: rtl/variance_unit.sv
// ============================================================================
// variance_unit
// Buffers one pixel block, takes its mean from the upstream stage and computes
// the floored population variance through a 3-stage read/square/accumulate pipe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module variance_unit #(
    parameter int DATA_WIDTH    = 8,
    parameter int TOTAL_SAMPLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    start_data_in,
    input  logic [2*DATA_WIDTH-1:0] mean_in,
    input  logic                    mean_ready,
    output logic [2*DATA_WIDTH-1:0] variance_out,
    output logic                    ready
);

    localparam int LOG2N = $clog2(TOTAL_SAMPLES);
    localparam int CNT_W = LOG2N + 1;
    localparam int ACC_W = 2*DATA_WIDTH + LOG2N;
    localparam int PRD_W = 2*DATA_WIDTH + 2;

    localparam logic [CNT_W-1:0] c_LAST_WR  = CNT_W'(TOTAL_SAMPLES - 1);
    localparam logic [CNT_W-1:0] c_NUM_RD   = CNT_W'(TOTAL_SAMPLES);
    localparam logic [CNT_W-1:0] c_LAST_ACC = CNT_W'(TOTAL_SAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WAIT    = 3'd2,
        S_ACCUM   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     mean_q, mean_d;
    logic                      mean_valid_q, mean_valid_d;
    logic [DATA_WIDTH-1:0]     x_q, x_d;
    logic                      v1_q, v1_d;
    logic [2*DATA_WIDTH-1:0]   sq_q, sq_d;
    logic                      v2_q, v2_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0]   var_q, var_d;
    logic                      ready_q, ready_d;

    logic [DATA_WIDTH-1:0]     mem_q [TOTAL_SAMPLES];
    logic                      w_wr_en;

    logic signed [DATA_WIDTH:0] w_diff;
    logic signed [PRD_W-1:0]    w_diff_ext;
    logic signed [PRD_W-1:0]    w_prod;
    logic                       w_unused_bits;

    assign w_diff     = $signed({1'b0, x_q}) - $signed({1'b0, mean_q});
    assign w_diff_ext = {{(PRD_W-DATA_WIDTH-1){w_diff[DATA_WIDTH]}}, w_diff};
    assign w_prod     = w_diff_ext * w_diff_ext;
    // Square of a (DW+1)-bit signed value never exceeds (2^DW-1)^2, so the top bits are always zero.
    assign w_unused_bits = &{1'b0, mean_in[2*DATA_WIDTH-1:DATA_WIDTH], w_prod[PRD_W-1:2*DATA_WIDTH]};

    assign variance_out = var_q;
    assign ready        = ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mean_d       = mean_q;
        mean_valid_d = mean_valid_q;
        x_d          = x_q;
        v1_d         = 1'b0;
        sq_d         = sq_q;
        v2_d         = 1'b0;
        acc_d        = acc_q;
        var_d        = var_q;
        ready_d      = 1'b0;
        w_wr_en      = 1'b0;

        if ((state_q == S_COLLECT || state_q == S_WAIT) && mean_ready) begin
            mean_d       = mean_in[DATA_WIDTH-1:0];
            mean_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_data_in) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                if (!start_data_in) begin
                    w_wr_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == c_LAST_WR) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (!start_data_in && mean_valid_q) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_ACCUM: begin
                cnt_d = cnt_q + CNT_W'(1);
                x_d   = mem_q[cnt_q[LOG2N-1:0]];
                v1_d  = (cnt_q < c_NUM_RD);
                sq_d  = w_prod[2*DATA_WIDTH-1:0];
                v2_d  = v1_q;
                if (v2_q) begin
                    acc_d = acc_q + {{LOG2N{1'b0}}, sq_q};
                end
                if (cnt_q == c_LAST_ACC) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                var_d        = acc_q[ACC_W-1:LOG2N];
                ready_d      = 1'b1;
                mean_valid_d = 1'b0;
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = start_data_in ? S_COLLECT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new start mid-block discards the partial work and restarts collection.
        if (start_data_in && (state_q == S_COLLECT || state_q == S_WAIT || state_q == S_ACCUM)) begin
            state_d      = S_COLLECT;
            cnt_d        = '0;
            mean_valid_d = 1'b0;
            acc_d        = '0;
            v1_d         = 1'b0;
            v2_d         = 1'b0;
            w_wr_en      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
            x_q          <= '0;
            v1_q         <= 1'b0;
            sq_q         <= '0;
            v2_q         <= 1'b0;
            acc_q        <= '0;
            var_q        <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
            x_q          <= x_d;
            v1_q         <= v1_d;
            sq_q         <= sq_d;
            v2_q         <= v2_d;
            acc_q        <= acc_d;
            var_q        <= var_d;
            ready_q      <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[cnt_q[LOG2N-1:0]] <= data_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_variance_unit.sv
// Bench for variance_unit: directed blocks, expected results queued at issue
// time and checked by an independent monitor when ready pulses.
`default_nettype none

module tb_variance_unit;

    localparam int DW = 8;
    localparam int N  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   data_in;
    logic            start_data_in;
    logic [2*DW-1:0] mean_in;
    logic            mean_ready;
    logic [2*DW-1:0] variance_out;
    logic            ready;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_q[$];
    int cyc_q[$];
    logic prev_ready = 1'b0;

    variance_unit #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .start_data_in (start_data_in),
        .mean_in       (mean_in),
        .mean_ready    (mean_ready),
        .variance_out  (variance_out),
        .ready         (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation in value and timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b0;
        end else begin
            if (ready) begin
                n_cmp++;
                if (prev_ready) begin
                    n_fail++;
                    $display("FAIL ready_consecutive: got ready high two cycles at cycle %0d, required single pulse", cyc);
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got pulse with variance %0d, required no pulse", variance_out);
                end else begin
                    int e, c;
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("variance_value", int'(variance_out), e);
                    check("ready_latency_cycle", cyc, c);
                end
            end
            prev_ready = ready;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sample(input int mode, input int i);
        case (mode)
            0:       return 8'd100;
            1:       return (i % 2) ? 8'd255 : 8'd0;
            default: return 8'(i);
        endcase
    endfunction

    task automatic run_block(input int mode, input int mean_val, input int mean_at,
                             input int exp_var, input bit push, input bit settle);
        int e0;
        data_in       = 8'hA5;
        start_data_in = 1'b1;
        mean_ready    = 1'b0;
        step();
        e0 = cyc;
        if (push) begin
            exp_q.push_back(exp_var);
            cyc_q.push_back(e0 + 2*N + 4);
        end
        start_data_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            data_in    = sample(mode, i);
            mean_ready = (i == mean_at);
            mean_in    = 16'(mean_val);
            step();
        end
        mean_ready = 1'b0;
        data_in    = '0;
        if (settle) repeat (N + 8) step();
    endtask

    initial begin
        rst           = 1'b1;
        data_in       = '0;
        start_data_in = 1'b0;
        mean_in       = '0;
        mean_ready    = 1'b0;
        repeat (3) step();
        check("reset_variance", int'(variance_out), 0);
        check("reset_ready", int'(ready), 0);
        rst = 1'b0;
        step();

        run_block(0, 100, N-1, 0,     1'b1, 1'b1);   // T1 constant
        run_block(1, 127, N-1, 16256, 1'b1, 1'b1);   // T2 alternating
        run_block(2, 31,  N-1, 341,   1'b1, 1'b1);   // T3 ramp
        run_block(2, 31,  9,   341,   1'b1, 1'b1);   // T4 early mean

        // T5: partial block aborted by a fresh start
        data_in       = 8'h11;
        start_data_in = 1'b1;
        step();
        start_data_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_in = sample(2, i);
            step();
        end
        check("hold_during_abort", int'(variance_out), 341);
        run_block(0, 100, N-1, 0, 1'b1, 1'b1);

        run_block(1, 127, N-1, 16256, 1'b1, 1'b1);

        // T6: reset in the middle of ACCUM
        run_block(1, 127, N-1, 0, 1'b0, 1'b0);
        repeat (20) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrun_reset_variance", int'(variance_out), 0);
        check("midrun_reset_ready", int'(ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        run_block(2, 31, N-1, 341, 1'b1, 1'b1);

        repeat (10) step();
        check("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
